// File: rtl/osu_target_manager_pkg.sv
// Shared constants for the rhythm-click target manager: event kinds,
// PS/2 prefix bytes, the per-slot key table and the game FSM encoding.
package osu_pkg;

  localparam logic [1:0] EV_SPAWN  = 2'd0;
  localparam logic [1:0] EV_HIT    = 2'd1;
  localparam logic [1:0] EV_EXPIRE = 2'd2;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // Slot i answers to SLOT_KEYS[i]: A S D F G H J K
  localparam logic [7:0][7:0] SLOT_KEYS = {8'h42, 8'h3B, 8'h33, 8'h34,
                                           8'h2B, 8'h23, 8'h1B, 8'h1C};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

endpackage

// File: rtl/osu_target_manager_lfsr_coord.sv
// Free-running 16-bit Galois LFSR producing folded on-screen coordinates.
module osu_lfsr_coord #(
  parameter int          X_MAX     = 304,
  parameter int          Y_MAX     = 214,
  parameter int          X_W       = 9,
  parameter int          Y_W       = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           clk,
  input  logic           reset,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [X_W-1:0] X_SUB = X_W'(X_MAX + 1);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] Y_SUB = Y_W'(Y_MAX + 1);

  logic [15:0]    lfsr_q;
  logic [X_W-1:0] x_raw;
  logic [Y_W-1:0] y_raw;

  // Advance the LFSR every cycle (taps 16,14,13,11, right-shifting form)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Fold raw values above the legal maximum back into range with one subtract
  always_comb begin
    x_raw = lfsr_q[X_W-1:0];
    y_raw = lfsr_q[15:16-Y_W];
    x = (x_raw > X_LIM) ? x_raw - X_SUB : x_raw;
    y = (y_raw > Y_LIM) ? y_raw - Y_SUB : y_raw;
  end

endmodule

// File: rtl/osu_target_manager.sv
// Multi-target game engine: slot lifetimes, spawning, PS/2 key matching,
// score/miss keeping and a valid/ready event stream to the VGA draw FSM.
module osu_target_manager
  import osu_pkg::*;
#(
  parameter int          NUM_TARGETS = 4,
  parameter int          X_MAX       = 304,
  parameter int          Y_MAX       = 214,
  parameter int          X_W         = 9,
  parameter int          Y_W         = 8,
  parameter int          TICK_DIV    = 833333,
  parameter int          LIFE_TICKS  = 180,
  parameter int          SPAWN_TICKS = 45,
  parameter int          MAX_MISS    = 5,
  parameter int          SCORE_W     = 10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             key_code,
  input  logic                   key_valid,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [1:0]             ev_kind,
  output logic [2:0]             ev_slot,
  output logic [X_W-1:0]         ev_x,
  output logic [Y_W-1:0]         ev_y,
  output logic [NUM_TARGETS-1:0] active,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     misses,
  output logic                   gameover
);

  localparam int LIFE_W = $clog2(LIFE_TICKS + 1);
  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int SPN_W  = $clog2(SPAWN_TICKS + 1);

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [3:0]         b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W+1)'(b);
    sat_add = s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  state_t                 state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [SPN_W-1:0]       spawn_q, spawn_d;
  logic                   brk_q, brk_d;
  logic [SCORE_W-1:0]     score_q, score_d, misses_q, misses_d;
  logic [NUM_TARGETS-1:0] active_q, active_d, pend_q, pend_d;
  logic                   lock_q, lock_d;
  logic [2:0]             sel_q, sel;
  logic [LIFE_W-1:0]      life_q [NUM_TARGETS];
  logic [LIFE_W-1:0]      life_d [NUM_TARGETS];
  logic [1:0]             kind_q [NUM_TARGETS];
  logic [1:0]             kind_d [NUM_TARGETS];
  logic [X_W-1:0]         x_q    [NUM_TARGETS];
  logic [X_W-1:0]         x_d    [NUM_TARGETS];
  logic [Y_W-1:0]         y_q    [NUM_TARGETS];
  logic [Y_W-1:0]         y_d    [NUM_TARGETS];

  logic [X_W-1:0] coord_x;
  logic [Y_W-1:0] coord_y;
  logic           run, tick, make, spawn_fire, spawn_ok, hit_any, key_match;
  logic [2:0]     spawn_slot;
  logic [3:0]     miss_cnt;

  osu_lfsr_coord #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_W(X_W), .Y_W(Y_W), .LFSR_SEED(LFSR_SEED)
  ) u_coord (
    .clk  (clk),
    .reset(reset),
    .x    (coord_x),
    .y    (coord_y)
  );

  // Present the lowest pending slot, frozen while the draw FSM stalls
  always_comb begin
    sel = sel_q;
    if (!lock_q) begin
      sel = 3'd0;
      for (int i = NUM_TARGETS - 1; i >= 0; i--)
        if (pend_q[i]) sel = 3'(i);
    end
    ev_valid = 1'b0;
    ev_kind  = 2'd0;
    ev_x     = '0;
    ev_y     = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (pend_q[i] && sel == 3'(i)) begin
        ev_valid = 1'b1;
        ev_kind  = kind_q[i];
        ev_x     = x_q[i];
        ev_y     = y_q[i];
      end
    end
    ev_slot  = ev_valid ? sel : 3'd0;
    active   = active_q;
    score    = score_q;
    misses   = misses_q;
    gameover = (state_q == ST_OVER);
  end

  // Game rules: tick/spawn timing, key decode, per-slot updates, FSM next state
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    spawn_d  = spawn_q;
    brk_d    = brk_q;
    active_d = active_q;
    pend_d   = pend_q;
    life_d   = life_q;
    kind_d   = kind_q;
    x_d      = x_q;
    y_d      = y_q;
    lock_d   = ev_valid && !ev_ready;
    hit_any  = 1'b0;
    miss_cnt = 4'd0;
    key_match = 1'b0;

    run  = (state_q == ST_RUN);
    tick = run && (tick_q == TICK_W'(TICK_DIV - 1));
    if (run) tick_d = tick ? '0 : tick_q + TICK_W'(1);
    spawn_fire = tick && (spawn_q == SPN_W'(SPAWN_TICKS - 1));
    if (tick) spawn_d = spawn_fire ? '0 : spawn_q + SPN_W'(1);

    // The byte after a break prefix is a release code and is dropped
    make = 1'b0;
    if (key_valid) begin
      if (brk_q)                       brk_d = 1'b0;
      else if (key_code == BREAK_CODE) brk_d = 1'b1;
      else if (key_code != EXT_CODE)   make  = run;
    end

    // Judge freeness on registered state so a slot hit this cycle cannot respawn
    spawn_ok   = 1'b0;
    spawn_slot = 3'd0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (!active_q[i] && !pend_q[i]) begin
        spawn_ok   = 1'b1;
        spawn_slot = 3'(i);
      end
    end

    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (ev_valid && ev_ready && sel == 3'(i)) pend_d[i] = 1'b0;
      key_match = make && (key_code == SLOT_KEYS[i]);
      if (key_match && active_q[i] && !pend_q[i]) begin
        active_d[i] = 1'b0;
        pend_d[i]   = 1'b1;
        kind_d[i]   = EV_HIT;
        hit_any     = 1'b1;
      end else if (key_match) begin
        miss_cnt = miss_cnt + 4'd1;
      end else if (tick && active_q[i] && !pend_q[i]) begin
        if (life_q[i] == LIFE_W'(1)) begin
          active_d[i] = 1'b0;
          pend_d[i]   = 1'b1;
          kind_d[i]   = EV_EXPIRE;
          miss_cnt    = miss_cnt + 4'd1;
        end else begin
          life_d[i] = life_q[i] - LIFE_W'(1);
        end
      end
      if (spawn_fire && spawn_ok && spawn_slot == 3'(i)) begin
        active_d[i] = 1'b1;
        pend_d[i]   = 1'b1;
        kind_d[i]   = EV_SPAWN;
        life_d[i]   = LIFE_W'(LIFE_TICKS);
        x_d[i]      = coord_x;
        y_d[i]      = coord_y;
      end
    end

    score_d  = sat_add(score_q, {3'd0, hit_any});
    misses_d = sat_add(misses_q, miss_cnt);

    case (state_q)
      ST_RUN:  if (misses_d >= SCORE_W'(MAX_MISS)) state_d = ST_OVER;
      default: state_d = state_q;
    endcase

    if (start) begin
      state_d  = ST_RUN;
      tick_d   = '0;
      spawn_d  = '0;
      score_d  = '0;
      misses_d = '0;
      active_d = '0;
      pend_d   = '0;
      lock_d   = 1'b0;
    end
  end

  // Game FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Control state: counters, flags, pending events, output lock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q   <= '0;
      spawn_q  <= '0;
      brk_q    <= 1'b0;
      score_q  <= '0;
      misses_q <= '0;
      active_q <= '0;
      pend_q   <= '0;
      lock_q   <= 1'b0;
      sel_q    <= 3'd0;
    end else begin
      tick_q   <= tick_d;
      spawn_q  <= spawn_d;
      brk_q    <= brk_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      lock_q   <= lock_d;
      sel_q    <= sel;
    end
  end

  // Slot payload: only observed through active/pending flags, so not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_TARGETS; i++) begin
      life_q[i] <= life_d[i];
      kind_q[i] <= kind_d[i];
      x_q[i]    <= x_d[i];
      y_q[i]    <= y_d[i];
    end
  end

endmodule
